// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the display scan multiplexer.
//   MODE_AUTO / MODE_MANUAL : encodings of the scan_mux mode input
//   DIV_50MHZ               : default slot length; 1 ms per digit at 50 MHz
// -----------------------------------------------------------------------------
package scan_pkg;

   localparam logic MODE_AUTO   = 1'b0;
   localparam logic MODE_MANUAL = 1'b1;

   localparam int DIV_50MHZ = 50000;

endpackage : scan_pkg

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Slot prescaler for the scan multiplexer. Counts 0..DIV-1 while enabled and
// flags the last cycle of each slot.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; pre holds when low
//   clr   in  synchronous clear of pre (has priority over en)
//   tick  out high while pre == DIV-1
// -----------------------------------------------------------------------------
module tick_divider
   import scan_pkg::*;
#(
   parameter int DIV = DIV_50MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // One spare bit so DIV-1 always fits, including DIV = 1.
   localparam int PW = $clog2(DIV) + 1;

   logic [PW-1:0] pre;

   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (clr) begin
         pre <= '0;
      end else if (en) begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

endmodule : tick_divider

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// N-channel registered multiplexer with automatic time-multiplexed scanning
// (digit scanning for the 7-segment display) or host-selected manual channel.
// Ports:
//   clk         in  system clock, rising edge
//   rst_n       in  asynchronous active-low reset
//   en          in  scan/output enable; low freezes the scan and zeroes outputs
//   mode        in  MODE_AUTO = scan, MODE_MANUAL = hold sel_manual
//   sel_manual  in  channel requested in manual mode (clamped to CHANNELS-1)
//   data_in     in  packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//   blank_mask  in  bit k = 1 blanks channel k
//   data_out    out registered data of the displayed channel
//   chan_onehot out registered one-hot strobe of the displayed channel
//   chan_idx    out current channel index (outputs lag it by one clock)
//   frame_done  out one-cycle pulse as the scan wraps back to channel 0
// -----------------------------------------------------------------------------
module scan_mux
   import scan_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 4,
   parameter int DIV      = DIV_50MHZ,
   parameter int IDXW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      mode,
   input  logic [IDXW-1:0]           sel_manual,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       blank_mask,
   output logic [WIDTH-1:0]          data_out,
   output logic [CHANNELS-1:0]       chan_onehot,
   output logic [IDXW-1:0]           chan_idx,
   output logic                      frame_done
);

   // Saturate a requested channel number to the last real channel.
   function automatic logic [IDXW-1:0] clamp_idx(input logic [IDXW-1:0] s);
      if (s > IDXW'(CHANNELS - 1)) begin
         return IDXW'(CHANNELS - 1);
      end
      return s;
   endfunction

   logic                auto_run;
   logic                manual_run;
   logic                tick;
   logic                last_idx;
   logic                wrap;
   logic [IDXW-1:0]     idx;
   logic [WIDTH-1:0]    slice_sel;
   logic [CHANNELS-1:0] onehot_sel;
   logic                blank_sel;

   // Output register stage
   logic [WIDTH-1:0]    data_p1;
   logic [CHANNELS-1:0] onehot_p1;
   logic                frame_p1;

   // en low overrides mode, so both run flags drop together.
   assign auto_run   = en && (mode == MODE_AUTO);
   assign manual_run = en && (mode == MODE_MANUAL);

   // Manual mode keeps pre at 0 so a switch back to auto gives the current
   // channel a full slot.
   tick_divider #(
      .DIV (DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (auto_run),
      .clr   (manual_run),
      .tick  (tick)
   );

   assign last_idx = (idx == IDXW'(CHANNELS - 1));
   assign wrap     = auto_run && tick && last_idx;
   assign chan_idx = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (manual_run) begin
         idx <= clamp_idx(sel_manual);
      end else if (auto_run && tick) begin
         // Explicit wrap: CHANNELS need not be a power of two.
         idx <= last_idx ? '0 : idx + IDXW'(1);
      end
   end

   // Decoded loop rather than a variable part-select keeps index widths exact.
   always_comb begin
      slice_sel  = '0;
      onehot_sel = '0;
      blank_sel  = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == IDXW'(k)) begin
            slice_sel     = data_in[k*WIDTH +: WIDTH];
            onehot_sel[k] = 1'b1;
            blank_sel     = blank_mask[k];
         end
      end
   end

   // Output stage: registered from the pre-edge index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1   <= '0;
         onehot_p1 <= '0;
         frame_p1  <= 1'b0;
      end else if (!en) begin
         data_p1   <= '0;
         onehot_p1 <= '0;
         frame_p1  <= 1'b0;
      end else begin
         data_p1   <= blank_sel ? '0 : slice_sel;
         onehot_p1 <= blank_sel ? '0 : onehot_sel;
         frame_p1  <= wrap;
      end
   end

   assign data_out    = data_p1;
   assign chan_onehot = onehot_p1;
   assign frame_done  = frame_p1;

endmodule : scan_mux

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
// Three scan_mux instances share one stimulus: A (4 ch, DIV=3), B (3 ch,
// DIV=3, exercises clamping and non-power-of-two wrap) and C (4 ch, DIV=1).
// A behavioural slot model per instance is compared every falling edge;
// hand-computed literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_scan_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        mode;
   logic [1:0]  sel;
   logic [15:0] din;
   logic [3:0]  mask;
   bit          chk_on;

   logic [3:0] dout_a, oh_a, dout_c, oh_c, dout_b;
   logic [2:0] oh_b;
   logic [1:0] idx_a, idx_b, idx_c;
   logic       fd_a, fd_b, fd_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scan_mux #(.CHANNELS(4), .WIDTH(4), .DIV(3)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel),
      .data_in(din), .blank_mask(mask), .data_out(dout_a),
      .chan_onehot(oh_a), .chan_idx(idx_a), .frame_done(fd_a));

   scan_mux #(.CHANNELS(3), .WIDTH(4), .DIV(3)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel),
      .data_in(din[11:0]), .blank_mask(mask[2:0]), .data_out(dout_b),
      .chan_onehot(oh_b), .chan_idx(idx_b), .frame_done(fd_b));

   scan_mux #(.CHANNELS(4), .WIDTH(4), .DIV(1)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel),
      .data_in(din), .blank_mask(mask), .data_out(dout_c),
      .chan_onehot(oh_c), .chan_idx(idx_c), .frame_done(fd_c));

   // Model: which channel is on display and how long it has been there.
   typedef struct {
      int chan;
      int elapsed;
      int dout;
      int oh;
      int fd;
   } ms_t;

   ms_t ma, mb, mc;

   function automatic ms_t mstep(ms_t s, int ch, int div);
      ms_t n = s;
      if (!en) begin
         n.dout = 0; n.oh = 0; n.fd = 0;
         return n;
      end
      if (mask[s.chan]) begin
         n.dout = 0; n.oh = 0;
      end else begin
         n.dout = int'((din >> (4 * s.chan)) & 16'hF);
         n.oh   = 1 << s.chan;
      end
      n.fd = 0;
      if (mode) begin
         n.chan    = (int'(sel) > ch - 1) ? ch - 1 : int'(sel);
         n.elapsed = 0;
      end else if (s.elapsed + 1 == div) begin
         n.elapsed = 0;
         n.chan    = (s.chan + 1) % ch;
         n.fd      = (n.chan == 0) ? 1 : 0;
      end else begin
         n.elapsed = s.elapsed + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= '{default: 0};
         mb <= '{default: 0};
         mc <= '{default: 0};
      end else begin
         ma <= mstep(ma, 4, 3);
         mb <= mstep(mb, 3, 3);
         mc <= mstep(mc, 4, 1);
      end
   end

   task automatic cmp(string nm, int d, int o, int i, int f, ms_t m);
      checks++;
      if (d != m.dout || o != m.oh || i != m.chan || f != m.fd) begin
         errors++;
         $display("FAIL model_%s t=%0t: got dout=%0d oh=%0d idx=%0d fd=%0d, expected dout=%0d oh=%0d idx=%0d fd=%0d",
                  nm, $time, d, o, i, f, m.dout, m.oh, m.chan, m.fd);
      end
   endtask

   task automatic lit(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("A", int'(dout_a), int'(oh_a), int'(idx_a), int'(fd_a), ma);
         cmp("B", int'(dout_b), int'(oh_b), int'(idx_b), int'(fd_b), mb);
         cmp("C", int'(dout_c), int'(oh_c), int'(idx_c), int'(fd_c), mc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a(int target, string nm);
      int n = 0;
      while (int'(idx_a) != target && n < 40) begin
         step();
         n++;
      end
      lit(nm, int'(idx_a), target);
   endtask

   initial begin
      int fa, fc;
      rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0;
      din = 16'h4321; mask = 4'b0000; chk_on = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      rst_n  = 1'b1;

      // Auto scan from reset: 1,2,3,4 each for 3 cycles
      fa = 0; fc = 0;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (c <= 12) begin
            fa += int'(fd_a);
            fc += int'(fd_c);
         end
         if (c == 1)  begin lit("scan_c1_dout", int'(dout_a), 1); lit("scan_c1_oh", int'(oh_a), 1); end
         if (c == 3)  lit("scan_c3_dout", int'(dout_a), 1);
         if (c == 4)  begin lit("scan_c4_dout", int'(dout_a), 2); lit("scan_c4_oh", int'(oh_a), 2); end
         if (c == 7)  begin lit("scan_c7_dout", int'(dout_a), 3); lit("scan_c7_oh", int'(oh_a), 4); end
         if (c == 10) begin lit("scan_c10_dout", int'(dout_a), 4); lit("scan_c10_oh", int'(oh_a), 8); end
         if (c == 11) lit("scan_c11_fd", int'(fd_a), 0);
         if (c == 12) begin lit("scan_c12_fd", int'(fd_a), 1); lit("scan_c12_idx", int'(idx_a), 0); end
         if (c == 13) begin lit("scan_c13_fd", int'(fd_a), 0); lit("scan_c13_dout", int'(dout_a), 1); end
      end
      lit("frame_count_a", fa, 1);
      lit("frame_count_div1", fc, 3);

      // Asynchronous reset mid-slot, checked before any clock edge
      #1 rst_n = 1'b0;
      #1;
      lit("rst_dout_a", int'(dout_a), 0);
      lit("rst_oh_a", int'(oh_a), 0);
      lit("rst_idx_c", int'(idx_c), 0);
      lit("rst_dout_b", int'(dout_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mask  = 4'b0100;
      step();
      lit("rel_dout", int'(dout_a), 1);
      lit("rel_idx", int'(idx_a), 0);

      // Blanking of channel 2 only
      wait_a(2, "wait_idx2");
      step();
      lit("blank_dout", int'(dout_a), 0);
      lit("blank_oh", int'(oh_a), 0);
      wait_a(3, "wait_idx3");
      step();
      lit("unblank_dout", int'(dout_a), 4);
      lit("unblank_oh", int'(oh_a), 8);

      // Enable low mid-slot for 5 cycles
      mask = 4'b0000;
      wait_a(1, "wait_idx1");
      step();
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         lit("dis_dout", int'(dout_a), 0);
         lit("dis_oh", int'(oh_a), 0);
         lit("dis_idx", int'(idx_a), 1);
      end
      en = 1'b1;
      step();
      lit("resume_idx", int'(idx_a), 1);
      lit("resume_dout", int'(dout_a), 2);
      step();
      lit("resume_adv", int'(idx_a), 2);

      // Manual select and clamp
      mode = 1'b1; sel = 2'd1;
      step();
      lit("man_idx_b", int'(idx_b), 1);
      step();
      lit("man_dout_b", int'(dout_b), 2);
      lit("man_fd_b", int'(fd_b), 0);
      sel = 2'd3;
      step();
      lit("clamp_idx_b", int'(idx_b), 2);
      lit("clamp_idx_a", int'(idx_a), 3);
      sel = 2'd2;
      repeat (2) step();

      // Manual -> auto from channel 2: full slot, then channel 3
      mode = 1'b0;
      step();
      lit("sw_e1_idx", int'(idx_a), 2);
      lit("sw_e1_dout", int'(dout_a), 3);
      step();
      lit("sw_e2_idx", int'(idx_a), 2);
      step();
      lit("sw_e3_idx", int'(idx_a), 3);
      step();
      lit("sw_e4_dout", int'(dout_a), 4);

      // Further scanning with mixed blanking and new data
      din  = 16'h9A5C;
      mask = 4'b1001;
      repeat (15) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_scan_mux

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit registered multiplexer with built-in time-multiplexed scanning, generalising the single-bit 2:1 mux into the display path of the microwave controller. In auto mode it cycles through all channels at a programmable slot rate (digit scanning for the 7-segment display). In manual mode it holds a host-selected channel. Per-channel blanking, one-hot channel strobes and an end-of-frame pulse let the display driver and timer logic synchronise to the scan.

## Interface
Parameters:
- CHANNELS, 4, number of input channels; legal range ≥ 2
- WIDTH, 4, bits per channel
- DIV, 50000, clock cycles per channel slot in auto mode; legal range ≥ 1
- IDXW, $clog2(CHANNELS), channel index width (derived; not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan/output enable
- mode  in  1  0 = auto scan, 1 = manual select
- sel_manual  in  IDXW  channel selected in manual mode
- data_in  in  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
- blank_mask  in  CHANNELS  bit k = 1 blanks channel k
- data_out  out  WIDTH  selected channel data, registered
- chan_onehot  out  CHANNELS  active-high strobe of the displayed channel, registered
- chan_idx  out  IDXW  current channel index
- frame_done  out  1  one-cycle pulse when the scan wraps to channel 0

## Operation
- State: prescaler pre (0..DIV-1) and index idx (0..CHANNELS-1); chan_idx = idx.
- Reset (rst_n low, asynchronous): pre, idx, data_out, chan_onehot and frame_done all go to 0 immediately. Registers are released on the first rising edge after rst_n goes high.
- en=0: pre and idx hold. Next edge forces data_out=0, chan_onehot=0 and frame_done=0.
- Auto mode (en=1, mode=0):
  - If pre==DIV-1: pre←0 and idx←(idx==CHANNELS-1 ? 0 : idx+1).
  - Otherwise: pre←pre+1.
  - With DIV=1 the index advances every cycle.
- Manual mode (en=1, mode=1):
  - idx←sel_manual; pre←0.
  - If sel_manual > CHANNELS-1, idx←CHANNELS-1 (clamped).
  - frame_done stays 0.
- Mode switch manual→auto: scanning resumes from the current idx with pre=0. No skipped or repeated slot beyond the current one.
- Output stage (en=1), updated every edge from the pre-edge idx:
  - data_out←data_in slice[idx] and chan_onehot←(1<<idx).
  - If blank_mask[idx]=1: data_out←0 and chan_onehot←0.
- frame_done←1 on the edge where idx wraps from CHANNELS-1 to 0 in auto mode; 0 on every other edge.
- Widths: the pre counter is sized $clog2(DIV)+1 bits and compares against DIV-1 without overflow. Index arithmetic wraps explicitly, never by natural overflow when CHANNELS is not a power of 2.

## Timing
- Slot length in auto mode: exactly DIV cycles per channel. Frame length: CHANNELS*DIV cycles.
- Latency:
  - data_in/blank_mask change → data_out/chan_onehot: 1 cycle.
  - idx change → data_out/chan_onehot: 1 cycle. Outputs lag chan_idx by one clock.
- frame_done is coincident with chan_idx becoming 0 and lasts exactly 1 cycle.
- sel_manual → chan_idx: 1 cycle. → data_out: 2 cycles.
- Simultaneous events:
  - en=0 overrides mode.
  - Reset overrides everything. Reset mid-slot restarts the scan at channel 0, pre=0.

## Structure
- Shared package scan_pkg holds:
  - MODE_AUTO=1'b0 and MODE_MANUAL=1'b1.
  - The default DIV value for the 50 MHz board clock.
- One sub-module, tick_divider (parameter DIV; ports clk, rst_n, en, clr → tick). It owns pre and asserts tick when pre==DIV-1.
- scan_mux owns the index, clamp, blanking and output registers.

## Test plan
- Reset: assert rst_n=0 mid-scan, with no clock edge → all outputs 0 immediately. Release → first slot is channel 0.
- Auto scan: CHANNELS=4, DIV=3, data_in=16'h4321, no blanking → data_out sequence 1,2,3,4, each held 3 cycles. chan_onehot sequence 0001,0010,0100,1000. frame_done high for 1 cycle every 12 cycles, when chan_idx returns to 0.
- Blanking: blank_mask=4'b0100 → during channel 2's slot, data_out=0 and chan_onehot=0. Other channels are unaffected.
- Manual and clamp: CHANNELS=3, mode=1:
  - sel_manual=1 → chan_idx=1 after 1 cycle, data_out=slice1 after 2 cycles, frame_done stays 0.
  - sel_manual=3 → chan_idx=2.
- Enable and mode switch:
  - en=0 for 5 cycles mid-slot → outputs 0, chan_idx frozen.
  - en=1 → the slot resumes with its remaining count.
  - Manual→auto from idx=2 → channel 2 held DIV cycles, then 3.
- DIV=1 → index advances every cycle; frame_done pulses every CHANNELS cycles.
